instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Writer-side counterpart of instruction memory. Receives a program as a byte stream (valid/ready) and packs each four bytes big-endian into one 32-bit instruction. It then drives the memory write port (WriteAddress, writeDataINS, writeINS) at consecutive word addresses from a programmable base. While loading it holds busy high so the core can be stalled.

Parameters:
CNT_W, 16, width of word-count input and progress counter
BASE_DEFAULT, 30'd0, word address used when base_sel=0

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle load request; sampled only in IDLE or DONE
base_sel  input  1  1: use base_addr; 0: use BASE_DEFAULT (sampled with start)
base_addr  input  30  word address [31:2] of first instruction
num_words  input  CNT_W  number of instructions to load (sampled with start)
abort  input  1  cancels load; partial word discarded
byte_in  input  8  program byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle
WriteAddress  output  30  word address to instruction memory
writeDataINS  output  32  instruction word to instruction memory
writeINS  output  1  write strobe to instruction memory, one cycle per word
busy  output  1  high from start acceptance until DONE/IDLE entered
done  output  1  high in DONE; cleared by next start or reset
words_written  output  CNT_W  count of words committed this load

Behaviour:
- Reset (async, rst=1): state=IDLE; byte_ready=0, writeINS=0, busy=0, done=0, WriteAddress=0, writeDataINS=0, words_written=0, byte counter=0, shift register=0. Reset mid-load discards all progress. Words already written stay in memory.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE/DONE + start:
  - Latch base address and num_words; words_written=0; done=0.
  - If num_words=0, go to DONE.
  - Otherwise go to COLLECT and set busy=1.
- COLLECT: byte_ready=1. A byte is accepted on any edge with byte_valid=1.
  - Each accept: shift <= {shift[23:0], byte_in}; byte counter increments mod 4. The first byte received ends up in bits [31:24].
  - On the 4th accept: writeDataINS <= packed word; WriteAddress <= current address; go to WRITE.
- WRITE: writeINS=1 for exactly one cycle; byte_ready=0. Memory captures the word at the edge that ends WRITE. On that edge:
  - words_written += 1.
  - Address += 1, wrapping 30'h3FFFFFFF -> 0 with no error.
  - If words_written+1 == num_words, go to DONE (busy=0, done=1); otherwise go to COLLECT.
- Latency and throughput: 4th byte accepted at edge N; writeINS is high during cycle N..N+1. Maximum throughput is 4 bytes per 5 cycles.
- writeINS is a registered output and is never asserted outside WRITE. WriteAddress and writeDataINS are stable for the whole WRITE cycle.
- start while busy (COLLECT/WRITE): ignored.
- abort:
  - In COLLECT: go to IDLE; busy=0, done=0; partial bytes and byte counter cleared.
  - In WRITE: the pending write completes this cycle, then go to IDLE instead of COLLECT/DONE.
  - Abort has priority over the DONE transition.
- abort and start in the same cycle in IDLE/DONE: start wins.
- byte_valid while byte_ready=0: not consumed; the source must hold it.
- DONE: outputs hold. start restarts a load; abort has no effect.

Decomposition:
- Shared package: state enum (IDLE, COLLECT, WRITE, DONE); constant BYTES_PER_WORD=4; byte counter width 2; INSTR_ADDR_W=30.
- One sub-module, instr_byte_packer: shift register plus mod-4 byte counter with clear input. It outputs the packed word and a word_complete pulse. The FSM, address counter and word counter stay in instr_mem_loader.

Test Plan:
- Basic load: base_sel=1, base_addr=30'd8, num_words=2; bytes 20,08,00,05,8C,09,00,04 sent back-to-back. Required: writeINS pulses twice, (8, 32'h20080005) then (9, 32'h8C090004); done=1; words_written=2; busy low after the 2nd WRITE.
- Backpressure gaps: byte_valid toggling every other cycle, num_words=1, bytes DE,AD,BE,EF. Required: one write of 32'hDEADBEEF at BASE_DEFAULT; byte_ready=0 during the WRITE cycle; no byte lost or duplicated.
- Zero length: num_words=0 with start. Required: DONE next cycle, done=1, writeINS never asserted, busy stays 0.
- Wrap-around: base_addr=30'h3FFFFFFF, num_words=2. Required: writes at 30'h3FFFFFFF then 30'h0.
- Abort mid-word: after 2 bytes, pulse abort. Required: IDLE, no writeINS. A new start with 4 bytes 11,22,33,44 writes 32'h11223344, proving stale bytes were cleared.
- Async reset mid-load: assert rst between clock edges during COLLECT. Required: all outputs 0 immediately without waiting for a clock edge; start after release begins a fresh load at the latched base.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// ==========================================================================
// instr_mem_loader_pkg: shared states and constants for the loader (rev 1.0)
// ==========================================================================
`default_nettype none

package instr_mem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;
  localparam int INSTR_ADDR_W   = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_byte_packer.sv
// ==========================================================================
// instr_byte_packer: big-endian byte-to-word packer, mod-4 count (rev 1.0)
// ==========================================================================
`default_nettype none

module instr_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  // Only the three older bytes need storage; the fourth is the live input.
  logic [23:0]           shift;
  logic [BYTE_CNT_W-1:0] cnt;

  assign word          = {shift, byte_in};
  assign word_complete = accept && (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shift <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shift <= {shift[15:0], byte_in};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ==========================================================================
// instr_mem_loader: byte-stream to instruction-memory write port (rev 1.0)
// ==========================================================================
`default_nettype none

module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                      CNT_W        = 16,
  parameter logic [INSTR_ADDR_W-1:0] BASE_DEFAULT = 30'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    base_sel,
  input  logic [INSTR_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]        num_words,
  input  logic                    abort,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [INSTR_ADDR_W-1:0] WriteAddress,
  output logic [31:0]             writeDataINS,
  output logic                    writeINS,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        words_written
);

  state_t                  state;
  state_t                  state_next;
  logic [INSTR_ADDR_W-1:0] addr;
  logic [CNT_W-1:0]        num_words_q;
  logic                    start_ok;
  logic                    accept;
  logic                    packer_clear;
  logic [31:0]             packed_word;
  logic                    word_complete;

  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept       = (state == ST_COLLECT) && byte_valid && !abort;
  assign packer_clear = start_ok || ((state == ST_COLLECT) && abort);

  assign byte_ready = (state == ST_COLLECT);
  assign busy       = (state == ST_COLLECT) || (state == ST_WRITE);
  assign done       = (state == ST_DONE);

  instr_byte_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clear         (packer_clear),
    .accept        (accept),
    .byte_in       (byte_in),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start)
          state_next = (num_words == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (abort)
          state_next = ST_IDLE;
        else if (word_complete)
          state_next = ST_WRITE;
      end
      ST_WRITE: begin
        // Abort still lets this write land, but overrides the DONE exit.
        if (abort)
          state_next = ST_IDLE;
        else if ((words_written + 1'b1) == num_words_q)
          state_next = ST_DONE;
        else
          state_next = ST_COLLECT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      writeINS      <= 1'b0;
      addr          <= '0;
      num_words_q   <= '0;
      words_written <= '0;
      WriteAddress  <= '0;
      writeDataINS  <= '0;
    end else begin
      state    <= state_next;
      writeINS <= (state_next == ST_WRITE);
      if (start_ok) begin
        addr          <= base_sel ? base_addr : BASE_DEFAULT;
        num_words_q   <= num_words;
        words_written <= '0;
      end
      if (word_complete) begin
        WriteAddress <= addr;
        writeDataINS <= packed_word;
      end
      if (state == ST_WRITE) begin
        words_written <= words_written + 1'b1;
        addr          <= addr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ==========================================================================
// tb_instr_mem_loader: directed self-checking bench for the loader (rev 1.0)
// ==========================================================================
`default_nettype none

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        base_sel = 1'b0;
  logic [29:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic        abort = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [29:0] WriteAddress;
  logic [31:0] writeDataINS;
  logic        writeINS;
  logic        busy;
  logic        done;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic        saw_busy = 1'b0;

  instr_mem_loader #(.CNT_W(16), .BASE_DEFAULT(30'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_sel      (base_sel),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .abort         (abort),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .WriteAddress  (WriteAddress),
    .writeDataINS  (writeDataINS),
    .writeINS      (writeINS),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // writeINS is high for a whole cycle, so the falling edge sees each write once.
  always @(negedge clk) begin
    if (busy) saw_busy = 1'b1;
    if (writeINS) begin
      wa_q.push_back(WriteAddress);
      wd_q.push_back(writeDataINS);
      check_eq("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
    end
  end

  task automatic do_start(input logic sel, input logic [29:0] base, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_sel = sel; base_addr = base; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    byte_in = b; byte_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!ok) check_eq("byte_accept_timeout", 64'd0, 64'd1);
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_ready", {63'd0, byte_ready}, 64'd0);
    check_eq("rst_wins", {63'd0, writeINS}, 64'd0);
    check_eq("rst_count", {48'd0, words_written}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Basic two-word load
    clear_log();
    do_start(1'b1, 30'd8, 16'd2);
    check_eq("basic_busy", {63'd0, busy}, 64'd1);
    send_word(32'h20080005, 1'b0);
    send_word(32'h8C090004, 1'b0);
    wait_done();
    check_eq("basic_nwr", wa_q.size(), 64'd2);
    if (wa_q.size() == 2) begin
      check_eq("basic_a0", {34'd0, wa_q[0]}, 64'd8);
      check_eq("basic_d0", {32'd0, wd_q[0]}, 64'h20080005);
      check_eq("basic_a1", {34'd0, wa_q[1]}, 64'd9);
      check_eq("basic_d1", {32'd0, wd_q[1]}, 64'h8C090004);
    end
    check_eq("basic_done", {63'd0, done}, 64'd1);
    check_eq("basic_busy_off", {63'd0, busy}, 64'd0);
    check_eq("basic_count", {48'd0, words_written}, 64'd2);

    // Backpressure gaps, default base
    clear_log();
    do_start(1'b0, 30'h155, 16'd1);
    send_word(32'hDEADBEEF, 1'b1);
    wait_done();
    check_eq("gap_nwr", wa_q.size(), 64'd1);
    if (wa_q.size() == 1) begin
      check_eq("gap_a0", {34'd0, wa_q[0]}, 64'd0);
      check_eq("gap_d0", {32'd0, wd_q[0]}, 64'hDEADBEEF);
    end
    check_eq("gap_count", {48'd0, words_written}, 64'd1);

    // Zero length
    clear_log();
    @(negedge clk); saw_busy = 1'b0;
    do_start(1'b1, 30'd5, 16'd0);
    check_eq("zero_done", {63'd0, done}, 64'd1);
    check_eq("zero_busy", {63'd0, busy}, 64'd0);
    check_eq("zero_count", {48'd0, words_written}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("zero_nwr", wa_q.size(), 64'd0);
    check_eq("zero_saw_busy", {63'd0, saw_busy}, 64'd0);

    // Address wrap-around
    clear_log();
    do_start(1'b1, 30'h3FFFFFFF, 16'd2);
    send_word(32'h01020304, 1'b0);
    send_word(32'hA5A55A5A, 1'b0);
    wait_done();
    check_eq("wrap_nwr", wa_q.size(), 64'd2);
    if (wa_q.size() == 2) begin
      check_eq("wrap_a0", {34'd0, wa_q[0]}, 64'h3FFFFFFF);
      check_eq("wrap_a1", {34'd0, wa_q[1]}, 64'd0);
      check_eq("wrap_d1", {32'd0, wd_q[1]}, 64'hA5A55A5A);
    end

    // Abort mid-word, then a clean load
    clear_log();
    do_start(1'b1, 30'd20, 16'd1);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_ready", {63'd0, byte_ready}, 64'd0);
    check_eq("abort_nwr", wa_q.size(), 64'd0);
    do_start(1'b1, 30'd20, 16'd1);
    send_word(32'h11223344, 1'b0);
    wait_done();
    check_eq("reload_nwr", wa_q.size(), 64'd1);
    if (wa_q.size() == 1) begin
      check_eq("reload_a0", {34'd0, wa_q[0]}, 64'd20);
      check_eq("reload_d0", {32'd0, wd_q[0]}, 64'h11223344);
    end

    // Asynchronous reset between edges
    clear_log();
    do_start(1'b1, 30'd40, 16'd2);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_ready", {63'd0, byte_ready}, 64'd0);
    check_eq("arst_waddr", {34'd0, WriteAddress}, 64'd0);
    check_eq("arst_wdata", {32'd0, writeDataINS}, 64'd0);
    check_eq("arst_count", {48'd0, words_written}, 64'd0);
    @(negedge clk); rst = 1'b0;
    do_start(1'b1, 30'd40, 16'd1);
    send_word(32'hA1B2C3D4, 1'b0);
    wait_done();
    check_eq("arst_nwr", wa_q.size(), 64'd1);
    if (wa_q.size() == 1) begin
      check_eq("arst_a0", {34'd0, wa_q[0]}, 64'd40);
      check_eq("arst_d0", {32'd0, wd_q[0]}, 64'hA1B2C3D4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
